// File: rtl/solve_linear_nxn_if.sv
// Stream bundle for the NxN solver: augmented-matrix input stream and beta output stream.
// A beat moves on any cycle where valid and ready are both high at the rising clock edge.
// The producer holds data (and last/singular) stable while valid is high and ready is low.
interface solve_linear_nxn_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_singular;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_singular
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_singular
  );
endinterface

// File: rtl/solve_linear_nxn.sv
// Gauss-Jordan solver with partial pivoting for an NxN signed fixed-point system.
// The reciprocal of each pivot comes from a bit-serial restoring divider.
module solve_linear_nxn #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int N     = 3,
  parameter int EPS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  solve_linear_nxn_if.slave io,
  output logic       busy,
  output logic [2:0] dbg_state
);
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int QW = 2 * FRAC + 1;
  localparam int XW = (QW > WIDTH) ? QW : WIDTH;
  localparam int DW = $clog2(2 * FRAC + 2);

  localparam logic [RW-1:0]    RLAST = RW'(N - 1);
  localparam logic [CW-1:0]    CLAST = CW'(N);
  localparam logic [DW-1:0]    DLAST = DW'(2 * FRAC + 1);
  localparam logic [WIDTH-1:0] MAXV  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic [WIDTH-1:0] EPSV  = WIDTH'(EPS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] PIVOT  = 3'd2;
  localparam logic [2:0] SWAP   = 3'd3;
  localparam logic [2:0] RECIP  = 3'd4;
  localparam logic [2:0] NORM   = 3'd5;
  localparam logic [2:0] ELIM   = 3'd6;
  localparam logic [2:0] OUTPUT = 3'd7;

  function automatic logic [WIDTH-1:0] sat_abs(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] ux;
    ux = x;
    if (ux == MINV) return MAXV;
    if (ux[WIDTH-1]) return (~ux) + 1'b1;
    return ux;
  endfunction

  function automatic logic signed [WIDTH-1:0] fmul(input logic signed [WIDTH-1:0] x,
                                                   input logic signed [WIDTH-1:0] y);
    logic signed [2*WIDTH-1:0] xe;
    logic signed [2*WIDTH-1:0] ye;
    logic signed [2*WIDTH-1:0] p;
    logic [WIDTH:0]            hi;
    xe = {{WIDTH{x[WIDTH-1]}}, x};
    ye = {{WIDTH{y[WIDTH-1]}}, y};
    p  = (xe * ye) >>> FRAC;
    hi = p[2*WIDTH-1:WIDTH-1];
    if ((&hi) || !(|hi)) return p[WIDTH-1:0];
    return p[2*WIDTH-1] ? MINV : MAXV;
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] x,
                                                      input logic signed [WIDTH-1:0] y);
    logic [WIDTH:0] d;
    d = {x[WIDTH-1], x} - {y[WIDTH-1], y};
    if (d[WIDTH] != d[WIDTH-1]) return d[WIDTH] ? MINV : MAXV;
    return d[WIDTH-1:0];
  endfunction

  logic signed [WIDTH-1:0] a [N][N+1];

  logic [2:0]              state;
  logic [RW-1:0]           i;
  logic [CW-1:0]           j;
  logic [RW-1:0]           k;
  logic [RW-1:0]           best_row;
  logic [WIDTH-1:0]        best_abs;
  logic [DW-1:0]           dcnt;
  logic [WIDTH:0]          rem;
  logic [QW-1:0]           q;
  logic signed [WIDTH-1:0] recip;
  logic signed [WIDTH-1:0] f;
  logic                    singular;
  logic                    ov;

  logic                    hs;
  logic [WIDTH-1:0]        cur_abs;
  logic                    take;
  logic [WIDTH-1:0]        nb;
  logic [RW-1:0]           nr;
  logic [WIDTH:0]          rem_sh;
  logic [WIDTH:0]          rem_nx;
  logic [QW-1:0]           q_nx;
  logic [WIDTH-1:0]        mag;
  logic                    piv_neg;
  logic signed [WIDTH-1:0] f_use;
  logic signed [WIDTH-1:0] elim_val;
  logic [RW-1:0]           ip1;
  logic [RW-1:0]           next_i;
  logic [RW-1:0]           elim_last;
  logic [RW-1:0]           first_row;

  assign io.in_ready     = (state == IDLE) || (state == LOAD);
  assign io.out_valid    = ov;
  assign io.out_data     = (ov && !singular) ? a[i][CLAST] : '0;
  assign io.out_last     = ov && (i == RLAST);
  assign io.out_singular = singular;
  assign busy            = (state != IDLE);
  assign dbg_state       = state;

  always_comb begin
    hs      = io.in_valid && io.in_ready;
    cur_abs = sat_abs(a[i][CW'(k)]);
    // Ties keep the earlier row, so only a strictly larger magnitude replaces it.
    take    = (i == k) || (cur_abs > best_abs);
    nb      = take ? cur_abs : best_abs;
    nr      = take ? i : best_row;

    rem_sh  = {rem[WIDTH-1:0], dcnt == '0};
    if (rem_sh >= {1'b0, best_abs}) begin
      rem_nx = rem_sh - {1'b0, best_abs};
      q_nx   = {q[QW-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh;
      q_nx   = {q[QW-2:0], 1'b0};
    end
    mag     = (XW'(q) > XW'(MAXV)) ? MAXV : WIDTH'(q);
    piv_neg = a[k][CW'(k)][WIDTH-1];

    // Column 0 uses the live factor; later columns use the latched copy.
    f_use     = (j == '0) ? a[i][CW'(k)] : f;
    elim_val  = sat_sub(a[i][j], fmul(f_use, a[k][j]));
    ip1       = i + 1'b1;
    next_i    = (ip1 == k) ? ip1 + 1'b1 : ip1;
    elim_last = (k == RLAST) ? RLAST - 1'b1 : RLAST;
    first_row = (k == '0) ? RW'(1) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      best_row <= '0;
      best_abs <= '0;
      dcnt     <= '0;
      rem      <= '0;
      q        <= '0;
      recip    <= '0;
      f        <= '0;
      singular <= 1'b0;
      ov       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          i     <= '0;
          j     <= CW'(1);
          state <= LOAD;
        end
        LOAD: if (hs) begin
          if (j == CLAST) begin
            j <= '0;
            if (i == RLAST) begin
              i     <= '0;
              k     <= '0;
              state <= PIVOT;
            end else begin
              i <= i + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        PIVOT: begin
          best_abs <= nb;
          best_row <= nr;
          if (i == RLAST) begin
            if (nb <= EPSV) begin
              singular <= 1'b1;
              ov       <= 1'b1;
              i        <= '0;
              state    <= OUTPUT;
            end else begin
              state <= SWAP;
            end
          end else begin
            i <= i + 1'b1;
          end
        end
        SWAP: begin
          dcnt  <= '0;
          rem   <= '0;
          q     <= '0;
          state <= RECIP;
        end
        RECIP: begin
          // 2*FRAC+1 quotient-bit cycles, then one cycle to saturate and restore the sign.
          if (dcnt == DLAST) begin
            recip <= piv_neg ? (~mag + 1'b1) : mag;
            j     <= '0;
            state <= NORM;
          end else begin
            rem  <= rem_nx;
            q    <= q_nx;
            dcnt <= dcnt + 1'b1;
          end
        end
        NORM: begin
          if (j == CLAST) begin
            j     <= '0;
            i     <= first_row;
            state <= ELIM;
          end else begin
            j <= j + 1'b1;
          end
        end
        ELIM: begin
          if (j == '0) f <= a[i][CW'(k)];
          if (j == CLAST) begin
            j <= '0;
            if (i == elim_last) begin
              if (k == RLAST) begin
                ov    <= 1'b1;
                i     <= '0;
                state <= OUTPUT;
              end else begin
                k     <= k + 1'b1;
                i     <= k + 1'b1;
                state <= PIVOT;
              end
            end else begin
              i <= next_i;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        OUTPUT: if (ov && io.out_ready) begin
          if (i == RLAST) begin
            ov       <= 1'b0;
            singular <= 1'b0;
            i        <= '0;
            state    <= IDLE;
          end else begin
            i <= i + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Matrix storage carries no reset; every element is rewritten by LOAD before use.
  always_ff @(posedge clk) begin
    case (state)
      IDLE:  if (hs) a[0][0] <= io.in_data;
      LOAD:  if (hs) a[i][j] <= io.in_data;
      SWAP:  if (best_row != k) begin
        a[k]        <= a[best_row];
        a[best_row] <= a[k];
      end
      NORM: begin
        a[k][j] <= fmul(a[k][j], recip);
        if (j == CLAST) a[k][CW'(k)] <= ONE;
      end
      ELIM:  a[i][j] <= elim_val;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_solve_linear_nxn.sv
// Directed bench for solve_linear_nxn: N=3 and N=2 instances, queue scoreboard per instance.
module tb_solve_linear_nxn;
  localparam int W   = 32;
  localparam int F   = 16;
  localparam int PER = 10;
  localparam logic [W-1:0] ONE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst;
  always #(PER/2) clk = ~clk;

  solve_linear_nxn_if #(.WIDTH(W)) if3 ();
  solve_linear_nxn_if #(.WIDTH(W)) if2 ();
  logic       busy3, busy2;
  logic [2:0] st3, st2;

  solve_linear_nxn #(.WIDTH(W), .FRAC(F), .N(3), .EPS(1)) dut3 (
    .clk(clk), .rst(rst), .io(if3), .busy(busy3), .dbg_state(st3));
  solve_linear_nxn #(.WIDTH(W), .FRAC(F), .N(2), .EPS(1)) dut2 (
    .clk(clk), .rst(rst), .io(if2), .busy(busy2), .dbg_state(st2));

  logic [W+1:0] exp_q3[$];
  logic [W+1:0] exp_q2[$];
  logic [W-1:0] stim[$];
  int  checks   = 0;
  int  failures = 0;
  bit  bp       = 1'b0;
  time t0[2];
  int  lat_exp[2];
  bit  lat_arm[2] = '{1'b0, 1'b0};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic stim_push(input logic [W-1:0] m[12], input int cnt);
    for (int x = 0; x < cnt; x++) stim.push_back(m[x]);
  endtask

  task automatic exp3(input bit s, input logic [W-1:0] b0, input logic [W-1:0] b1,
                      input logic [W-1:0] b2);
    exp_q3.push_back({s, 1'b0, b0});
    exp_q3.push_back({s, 1'b0, b1});
    exp_q3.push_back({s, 1'b1, b2});
  endtask

  task automatic exp2(input bit s, input logic [W-1:0] b0, input logic [W-1:0] b1);
    exp_q2.push_back({s, 1'b0, b0});
    exp_q2.push_back({s, 1'b1, b1});
  endtask

  task automatic drive(input int sel, input logic v, input logic [W-1:0] d);
    if (sel == 0) begin if3.in_valid = v; if3.in_data = d; end
    else          begin if2.in_valid = v; if2.in_data = d; end
  endtask

  task automatic send(input int sel, input bit toggle, input int lat);
    int  guard;
    logic rdy;
    while (stim.size() > 0) begin
      @(negedge clk);
      if (toggle && $urandom_range(0, 1) == 0) begin
        drive(sel, 1'b0, W'($urandom));
        continue;
      end
      guard = 0;
      rdy = (sel == 0) ? if3.in_ready : if2.in_ready;
      while (!rdy && guard < 3000) begin
        @(negedge clk);
        guard++;
        rdy = (sel == 0) ? if3.in_ready : if2.in_ready;
      end
      if (!rdy) begin
        check("in_ready_timeout", 64'(rdy), 64'd1);
        stim.delete();
        drive(sel, 1'b0, '0);
        return;
      end
      drive(sel, 1'b1, stim.pop_front());
      @(posedge clk);
      t0[sel] = $time;
    end
    @(negedge clk);
    drive(sel, 1'b0, W'($urandom));
    if (lat > 0) begin
      lat_exp[sel] = lat;
      lat_arm[sel] = 1'b1;
    end
    if (sel == 0) check("busy_noready3", {if3.in_ready, busy3}, 64'b01);
    else          check("busy_noready2", {if2.in_ready, busy2}, 64'b01);
  endtask

  task automatic wait_drain(input int budget);
    int g = 0;
    while ((exp_q3.size() != 0 || exp_q2.size() != 0 || if3.out_valid || if2.out_valid)
           && g < budget) begin
      @(negedge clk);
      g++;
    end
    check("drain", 64'(exp_q3.size() + exp_q2.size()), 64'd0);
  endtask

  // ---------------- out_ready backpressure for the N=3 instance ----------------
  initial begin
    int stall = 0;
    if3.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (!bp) begin
        if3.out_ready = 1'b1;
        stall = 0;
      end else if (if3.out_ready) begin
        if3.out_ready = 1'b0;
        stall = 0;
      end else if (if3.out_valid) begin
        stall++;
        if (stall >= 5) if3.out_ready = 1'b1;
      end
    end
  end

  // ---------------- monitors / scoreboard ----------------
  initial begin
    logic [W+1:0] got, held;
    bit hold_v = 1'b0;
    forever begin
      @(negedge clk);
      got = {if3.out_singular, if3.out_last, if3.out_data};
      if (if3.out_valid) begin
        if (lat_arm[0]) begin
          lat_arm[0] = 1'b0;
          check("latency3", 64'(($time - PER/2 - t0[0]) / PER + 1), 64'(lat_exp[0]));
        end
        if (hold_v) check("stable3", 64'(got), 64'(held));
        if (if3.out_ready) begin
          hold_v = 1'b0;
          if (exp_q3.size() == 0) check("unexpected3", 64'(got), 64'hDEAD);
          else check("beta3", 64'(got), 64'(exp_q3.pop_front()));
        end else begin
          hold_v = 1'b1;
          held   = got;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    logic [W+1:0] got;
    forever begin
      @(negedge clk);
      got = {if2.out_singular, if2.out_last, if2.out_data};
      if (if2.out_valid) begin
        if (lat_arm[1]) begin
          lat_arm[1] = 1'b0;
          check("latency2", 64'(($time - PER/2 - t0[1]) / PER + 1), 64'(lat_exp[1]));
        end
        if (if2.out_ready) begin
          if (exp_q2.size() == 0) check("unexpected2", 64'(got), 64'hDEAD);
          else check("beta2", 64'(got), 64'(exp_q2.pop_front()));
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int g;
    rst = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    if2.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(if3.in_ready), 64'd1);
    check("rst_outs", {if3.out_valid, if3.out_last, if3.out_singular, busy3}, 64'd0);
    check("rst_data", 64'(if3.out_data), 64'd0);
    check("rst_state", 64'(st3), 64'd0);
    rst = 1'b0;

    // identity
    exp3(1'b0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000);
    stim_push('{ONE, 0, 0, 32'h10000, 0, ONE, 0, 32'h20000, 0, 0, ONE, 32'h30000}, 12);
    send(0, 1'b0, 148);
    // row exchange needed
    exp3(1'b0, 32'h0004_0000, 32'h0003_0000, 32'h0003_0000);
    stim_push('{0, ONE, 0, 32'h30000, ONE, 0, 0, 32'h40000, 0, 0, 32'h20000, 32'h60000}, 12);
    send(0, 1'b0, 148);
    // signs and fractions
    exp3(1'b0, 32'hFFFF_8000, 32'h0000_4000, 32'h0002_0000);
    stim_push('{32'hFFFE_0000, 0, 0, ONE, 0, 32'h40000, 0, ONE, 0, 0, 32'h8000, ONE}, 12);
    send(0, 1'b0, 148);
    // singular
    exp3(1'b1, 32'h0, 32'h0, 32'h0);
    stim_push('{ONE, 32'h20000, 32'h30000, ONE, 32'h20000, 32'h40000, 32'h60000, 32'h20000,
                ONE, ONE, ONE, 32'h30000}, 12);
    send(0, 1'b0, 0);
    wait_drain(2000);

    // input gaps and output backpressure
    bp = 1'b1;
    exp3(1'b0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000);
    stim_push('{ONE, 0, 0, 32'h10000, 0, ONE, 0, 32'h20000, 0, 0, ONE, 32'h30000}, 12);
    send(0, 1'b1, 148);
    exp3(1'b0, 32'h0004_0000, 32'h0003_0000, 32'h0003_0000);
    stim_push('{0, ONE, 0, 32'h30000, ONE, 0, 0, 32'h40000, 0, 0, 32'h20000, 32'h60000}, 12);
    send(0, 1'b1, 148);
    wait_drain(3000);
    bp = 1'b0;

    // reset while the divider runs; no result expected from the aborted problem
    stim_push('{ONE, 0, 0, 32'h10000, 0, ONE, 0, 32'h20000, 0, 0, ONE, 32'h30000}, 12);
    send(0, 1'b0, 0);
    g = 0;
    while (st3 != 3'd4 && g < 2000) begin @(negedge clk); g++; end
    check("reach_recip", 64'(st3), 64'd4);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_outs", {if3.out_valid, busy3, if3.in_ready}, 64'b001);
    check("midrst_state", 64'(st3), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp3(1'b0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000);
    stim_push('{ONE, 0, 0, 32'h10000, 0, ONE, 0, 32'h20000, 0, 0, ONE, 32'h30000}, 12);
    send(0, 1'b0, 148);

    // N=2 instance
    exp2(1'b0, 32'h0001_0000, 32'h0000_8000);
    stim_push('{32'h20000, 0, 32'h20000, 0, 32'h40000, 32'h20000, 0, 0, 0, 0, 0, 0}, 6);
    send(1, 1'b0, 86);
    wait_drain(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
